ysyx_lsu: RTL



---
 rtl/ysyx_lsu_if.sv | 32 +++
 rtl/ysyx_lsu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ysyx_lsu_if.sv
// rtl/ysyx_lsu_if.sv - AXI4-Lite data-bus bundle between the LSU (master) and memory (slave)
interface ysyx_lsu_if #(
  parameter int BIT_W = 32
);
  logic [BIT_W-1:0] araddr;
  logic             arvalid;
  logic             arready;
  logic [BIT_W-1:0] rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;
  logic [BIT_W-1:0] awaddr;
  logic             awvalid;
  logic             awready;
  logic [BIT_W-1:0] wdata_bus;
  logic [3:0]       wstrb;
  logic             wvalid;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata_bus, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata_bus, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_lsu.sv
// rtl/ysyx_lsu.sv - load/store unit: one EXU request at a time, one AXI4-Lite beat,
// lane alignment, strobes, load extension and misalignment errors
module ysyx_lsu #(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_avalid,
  input  logic             ren,
  input  logic             wen,
  input  logic [BIT_W-1:0] addr,
  input  logic [BIT_W-1:0] wdata,
  input  logic [2:0]       func3,
  output logic [BIT_W-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             wready_o,
  output logic             err_o,
  ysyx_lsu_if.master       bus
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RESP} state_t;

  state_t     state;
  logic [1:0] off;
  logic [2:0] f3;
  logic       aw_done;
  logic       w_done;
  logic       misalign;
  logic       aw_ok;
  logic       w_ok;
  logic [BIT_W-1:0] shifted;
  logic [BIT_W-1:0] ext;

  assign misalign = ((func3[1:0] == 2'b01) && addr[0]) ||
                    ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  // Either channel counts as done once its handshake has happened, possibly this cycle.
  assign aw_ok = aw_done || (bus.awvalid && bus.awready);
  assign w_ok  = w_done  || (bus.wvalid  && bus.wready);

  always_comb begin
    shifted = bus.rdata >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   ext = {{(BIT_W-8){~f3[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   ext = {{(BIT_W-16){~f3[2] & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      off           <= 2'b00;
      f3            <= 3'b000;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      rdata_o       <= '0;
      rvalid_o      <= 1'b0;
      wready_o      <= 1'b0;
      err_o         <= 1'b0;
      bus.araddr    <= '0;
      bus.arvalid   <= 1'b0;
      bus.rready    <= 1'b0;
      bus.awaddr    <= '0;
      bus.awvalid   <= 1'b0;
      bus.wdata_bus <= '0;
      bus.wstrb     <= 4'b0000;
      bus.wvalid    <= 1'b0;
      bus.bready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_avalid && (ren || wen)) begin
            off           <= addr[1:0];
            f3            <= func3;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            bus.araddr    <= {addr[BIT_W-1:2], 2'b00};
            bus.awaddr    <= {addr[BIT_W-1:2], 2'b00};
            bus.wdata_bus <= wdata << {addr[1:0], 3'b000};
            case (func3[1:0])
              2'b00:   bus.wstrb <= 4'b0001 << addr[1:0];
              2'b01:   bus.wstrb <= 4'b0011 << addr[1:0];
              default: bus.wstrb <= 4'b1111;
            endcase
            if (misalign) begin
              state    <= RESP;
              err_o    <= 1'b1;
              rvalid_o <= ~wen;
              wready_o <= wen;
              if (!wen) rdata_o <= '0;
            end else if (wen) begin
              state       <= WR_AW;
              bus.awvalid <= 1'b1;
              bus.wvalid  <= 1'b1;
            end else begin
              state       <= RD_A;
              bus.arvalid <= 1'b1;
            end
          end
        end
        RD_A: begin
          if (bus.arready) begin
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
            state       <= RD_D;
          end
        end
        RD_D: begin
          if (bus.rvalid) begin
            bus.rready <= 1'b0;
            rdata_o    <= ext;
            err_o      <= (bus.rresp != 2'b00);
            rvalid_o   <= 1'b1;
            state      <= RESP;
          end
        end
        WR_AW: begin
          if (bus.awvalid && bus.awready) begin
            bus.awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (bus.wvalid && bus.wready) begin
            bus.wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            bus.bready <= 1'b1;
            state      <= WR_B;
          end
        end
        WR_B: begin
          if (bus.bvalid) begin
            bus.bready <= 1'b0;
            err_o      <= (bus.bresp != 2'b00);
            wready_o   <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          rvalid_o <= 1'b0;
          wready_o <= 1'b0;
          err_o    <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
